cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step/breakpoint controller for a single-clock CPU pipeline. The pipeline
// advances one clk_cpu edge for every one-clk pulse on cpu_en.
//
// Optional feature macro: CYCLE_CNT_EN
//   defined   -> cycle_cnt counts issued cpu_en pulses (saturating), cnt_clr
//                clears it and wins over a coincident pulse
//   undefined -> cycle_cnt is tied to 0 and cnt_clr is ignored
//
// Parameters
//   RUN_DIV   clk cycles per cpu_en pulse while running (2..65535)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous active-low reset
//   step_btn   in   debounced step request (level)
//   run_sw     in   run enable (level)
//   bp_en      in   breakpoint enable
//   bp_addr    in   [31:0] breakpoint PC
//   pc         in   [31:0] current fetch PC of the pipeline
//   cnt_clr    in   synchronous clear of cycle_cnt
//   cpu_en     out  one-clk advance pulse
//   halted     out  high in HALT or BREAK
//   bp_hit     out  high in BREAK
//   state      out  [1:0] HALT=00 STEP=01 RUN=10 BREAK=11
//   cycle_cnt  out  [31:0] number of cpu_en pulses issued
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned RUN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_btn,
  input  logic        run_sw,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic        cnt_clr,
  output logic        cpu_en,
  output logic        halted,
  output logic        bp_hit,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

  state_t      r_state;
  logic        r_step_prev;
  logic        r_bp_skip;
  logic        r_cpu_en;
  logic        r_halted;
  logic        r_bp_hit;
  logic [15:0] r_div_cnt;

  logic        w_step_edge;
  logic        w_match;
  logic [15:0] w_div_inc;
  logic        w_div_hit;

  assign w_step_edge = step_btn & ~r_step_prev;
  // The skip flag masks the breakpoint so that a resume can execute the
  // instruction sitting at the breakpoint PC.
  assign w_match     = bp_en & (pc == bp_addr) & ~r_bp_skip;
  assign w_div_inc   = r_div_cnt + 16'd1;
  // The pulse is registered together with div_cnt reaching its last value,
  // so cpu_en is high exactly while div_cnt == RUN_DIV-1.
  assign w_div_hit   = (w_div_inc == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_HALT;
      r_step_prev <= 1'b0;
      r_bp_skip   <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_halted    <= 1'b1;
      r_bp_hit    <= 1'b0;
      r_div_cnt   <= 16'd0;
    end else begin
      r_step_prev <= step_btn;
      r_cpu_en    <= 1'b0;
      // A pulse was issued in the previous clk: the breakpoint is passed.
      if (r_cpu_en) begin
        r_bp_skip <= 1'b0;
      end

      case (r_state)
        S_HALT: begin
          if (run_sw) begin
            r_state   <= S_RUN;
            r_div_cnt <= 16'd0;
            r_halted  <= 1'b0;
            r_bp_hit  <= 1'b0;
          end else if (w_step_edge) begin
            r_state  <= S_STEP;
            r_cpu_en <= 1'b1;
            r_halted <= 1'b0;
            r_bp_hit <= 1'b0;
          end
        end

        S_STEP: begin
          // A step always returns to HALT, even with run_sw high.
          r_state   <= S_HALT;
          r_div_cnt <= 16'd0;
          r_halted  <= 1'b1;
          r_bp_hit  <= 1'b0;
        end

        S_RUN: begin
          if (!run_sw) begin
            r_state   <= S_HALT;
            r_div_cnt <= 16'd0;
            r_halted  <= 1'b1;
            r_bp_hit  <= 1'b0;
          end else if (w_div_hit && w_match) begin
            // Suppress the pulse that would have executed the breakpoint PC.
            r_state   <= S_BREAK;
            r_div_cnt <= 16'd0;
            r_halted  <= 1'b1;
            r_bp_hit  <= 1'b1;
            r_bp_skip <= 1'b1;
          end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? 16'd0 : w_div_inc;
            r_cpu_en  <= w_div_hit;
          end
        end

        S_BREAK: begin
          if (!run_sw) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_step_edge) begin
            r_state  <= S_STEP;
            r_cpu_en <= 1'b1;
            r_halted <= 1'b0;
            r_bp_hit <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
          r_bp_hit <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en = r_cpu_en;
  assign halted = r_halted;
  assign bp_hit = r_bp_hit;
  assign state  = r_state;

`ifdef CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic        w_issue;

  // Same conditions that set r_cpu_en above, so the count moves in the
  // same clk the pulse becomes visible.
  assign w_issue = ((r_state == S_HALT)  & ~run_sw & w_step_edge) |
                   ((r_state == S_BREAK) &  run_sw & w_step_edge) |
                   ((r_state == S_RUN)   &  run_sw & w_div_hit & ~w_match);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= 32'd0;
    end else if (cnt_clr) begin
      r_cycle_cnt <= 32'd0;
    end else if (w_issue && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign cycle_cnt        = 32'd0;
`endif

endmodule
